anim_frame_ctrl: RTL and testbench

// - Frame-sequencing controller for the sprite renderer; drives the coordinate/colour datapath and VGA plot.
// - Loops DRAW -> CHECK -> WAIT -> ERASE -> LOAD -> DRAW over NUM_OBJ sprites, each PIX_CNT pixels.
// - Detects game-over from touch_edge and holds until restart.
// - Parametrised successor to the single-sprite control FSM: adds object count, pixel/frame sizing and a game-over hold.

---
 rtl/anim_frame_ctrl.sv | 102 ++++++++++
 tb/tb_anim_frame_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/anim_frame_ctrl.sv
// Frame-sequencing controller: DRAW -> CHECK -> WAIT -> ERASE -> LOAD over NUM_OBJ sprites, with a game-over hold.
// Optional build macro ANIM_PAUSE_EN lets the pause input freeze the WAIT frame timer.
module anim_frame_ctrl #(
  parameter int FRAME_TICKS = 1666667,
  parameter int PIX_CNT     = 16,
  parameter int NUM_OBJ     = 2,
  parameter int PIX_W       = (PIX_CNT > 1) ? $clog2(PIX_CNT) : 1,
  parameter int OBJ_W       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             touch_edge,
  input  logic             restart,
  input  logic             pause,
  output logic             plot,
  output logic [1:0]       op,
  output logic             move_en,
  output logic             load_coord,
  output logic [OBJ_W-1:0] obj_sel,
  output logic [PIX_W-1:0] pix_idx,
  output logic             game_over
);

  localparam int WAIT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [2:0] S_DRAW  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ERASE = 3'd3;
  localparam logic [2:0] S_LOAD  = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_CNT - 1);
  localparam logic [OBJ_W-1:0]  OBJ_LAST  = OBJ_W'(NUM_OBJ - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FRAME_TICKS - 1);

  logic [2:0]        state;
  logic [PIX_W-1:0]  pix_q;
  logic [OBJ_W-1:0]  obj_q;
  logic [WAIT_W-1:0] wait_q;

  logic sweep, pix_end, pass_end, wait_hold, wait_end, over_exit;

`ifdef ANIM_PAUSE_EN
  assign wait_hold = pause;
`else
  // pause is a dead input in this build; folded to zero so the port stays wired
  assign wait_hold = pause & 1'b0;
`endif

  assign sweep     = (state == S_DRAW) || (state == S_ERASE) || (state == S_OVER);
  assign pix_end   = (pix_q == PIX_LAST);
  assign pass_end  = sweep && pix_end && (obj_q == OBJ_LAST);
  assign wait_end  = (state == S_WAIT) && !wait_hold && (wait_q == WAIT_LAST);
  assign over_exit = (state == S_OVER) && restart;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_DRAW;
    end else begin
      case (state)
        S_DRAW:  if (pass_end) state <= S_CHECK;
        S_CHECK: state <= touch_edge ? S_OVER : S_WAIT;
        S_WAIT:  if (wait_end) state <= S_ERASE;
        S_ERASE: if (pass_end) state <= S_LOAD;
        S_LOAD:  state <= S_DRAW;
        S_OVER:  if (restart) state <= S_DRAW;
        default: state <= S_DRAW;
      endcase
    end
  end

  // Sprite/pixel sweep; outside the plotting states the counters sit at zero
  always_ff @(posedge clk) begin
    if (!reset_n || over_exit || !sweep) begin
      pix_q <= '0;
      obj_q <= '0;
    end else if (pix_end) begin
      pix_q <= '0;
      obj_q <= (obj_q == OBJ_LAST) ? '0 : obj_q + 1'b1;
    end else begin
      pix_q <= pix_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || state != S_WAIT) begin
      wait_q <= '0;
    end else if (!wait_hold) begin
      wait_q <= (wait_q == WAIT_LAST) ? '0 : wait_q + 1'b1;
    end
  end

  assign plot       = sweep;
  assign op         = (state == S_ERASE) ? 2'b01 : (state == S_OVER) ? 2'b10 : 2'b00;
  assign move_en    = (state == S_DRAW) || (state == S_WAIT) || (state == S_ERASE);
  assign load_coord = (state == S_LOAD);
  assign game_over  = (state == S_OVER);
  assign obj_sel    = obj_q;
  assign pix_idx    = pix_q;

endmodule

// File: tb/tb_anim_frame_ctrl.sv
// Phase-table bench for anim_frame_ctrl (FRAME_TICKS=8, PIX_CNT=4, NUM_OBJ=2) with an expected-output queue.
module tb_anim_frame_ctrl;

  localparam int FT = 8;
  localparam int PC = 4;
  localparam int NO = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       touch_edge = 1'b0;
  logic       restart = 1'b0;
  logic       pause = 1'b0;
  logic       plot, move_en, load_coord, game_over;
  logic [1:0] op;
  logic [0:0] obj_sel;
  logic [1:0] pix_idx;

  anim_frame_ctrl #(.FRAME_TICKS(FT), .PIX_CNT(PC), .NUM_OBJ(NO)) dut (
    .clk(clk), .reset_n(reset_n), .touch_edge(touch_edge), .restart(restart), .pause(pause),
    .plot(plot), .op(op), .move_en(move_en), .load_coord(load_coord),
    .obj_sel(obj_sel), .pix_idx(pix_idx), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rn, tch, rst, pse;
    int         len;
    logic       sw;
    int         base;
    logic       pl;
    logic [1:0] o;
    logic       me, ld, go;
  } phase_t;

  typedef struct {
    int         cyc;
    logic       pl;
    logic [1:0] o;
    logic       me, ld, go;
    int         obj, pix;
  } exp_t;

  phase_t tbl[$];
  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  function automatic phase_t ph(input logic rn, tch, rst, pse, input int len, input logic sw,
                                input int base, input logic pl, input logic [1:0] o,
                                input logic me, ld, go);
    phase_t p;
    p.rn = rn; p.tch = tch; p.rst = rst; p.pse = pse; p.len = len; p.sw = sw; p.base = base;
    p.pl = pl; p.o = o; p.me = me; p.ld = ld; p.go = go;
    return p;
  endfunction

  // Shorthand for the fixed output patterns of each state
  function automatic phase_t draw(input logic rn, tch, rst, pse, input int len, input int base);
    return ph(rn, tch, rst, pse, len, 1'b1, base, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic phase_t erase(input logic rn, tch, rst, pse, input int len, input int base);
    return ph(rn, tch, rst, pse, len, 1'b1, base, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic phase_t check(input logic tch, rst);
    return ph(1'b1, tch, rst, 1'b0, 1, 1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic phase_t wt(input logic tch, rst, pse, input int len);
    return ph(1'b1, tch, rst, pse, len, 1'b0, 0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic phase_t load();
    return ph(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic phase_t over(input logic rn, rst, input int len, input int base);
    return ph(rn, 1'b0, rst, 1'b0, len, 1'b1, base, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
  endfunction

  // Each cycle's outputs are checked on the falling edge against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (plot !== e.pl || op !== e.o || move_en !== e.me || load_coord !== e.ld ||
          game_over !== e.go || obj_sel !== 1'(e.obj) || pix_idx !== 2'(e.pix)) begin
        errors++;
        $display("FAIL cyc%0d outputs: got plot=%b op=%b move=%b load=%b go=%b obj=%0d pix=%0d want plot=%b op=%b move=%b load=%b go=%b obj=%0d pix=%0d",
                 e.cyc, plot, op, move_en, load_coord, game_over, obj_sel, pix_idx,
                 e.pl, e.o, e.me, e.ld, e.go, e.obj, e.pix);
      end
    end
  end

  initial begin
    // first cycle is still in reset: reset state, then released
    tbl.push_back(draw(1'b1, 1'b0, 1'b0, 1'b0, 8, 0));
    tbl.push_back(check(1'b0, 1'b0));
    tbl.push_back(wt(1'b0, 1'b0, 1'b0, FT));
    tbl.push_back(erase(1'b1, 1'b0, 1'b0, 1'b0, 8, 0));
    tbl.push_back(load());
    // restart held and touch_edge high outside CHECK: no effect
    tbl.push_back(draw(1'b1, 1'b1, 1'b1, 1'b0, 8, 0));
    tbl.push_back(check(1'b0, 1'b1));
    tbl.push_back(wt(1'b1, 1'b1, 1'b0, FT));
    tbl.push_back(erase(1'b1, 1'b0, 1'b0, 1'b0, 8, 0));
    tbl.push_back(load());
    // collision -> OVER sweeps and wraps, restart on the last cycle
    tbl.push_back(draw(1'b1, 1'b0, 1'b0, 1'b0, 8, 0));
    tbl.push_back(check(1'b1, 1'b0));
    tbl.push_back(over(1'b1, 1'b0, 9, 0));
    tbl.push_back(over(1'b1, 1'b1, 1, 9));
    // pause in DRAW is ignored; pause in WAIT
    tbl.push_back(draw(1'b1, 1'b0, 1'b0, 1'b1, 8, 0));
    tbl.push_back(check(1'b0, 1'b0));
    tbl.push_back(wt(1'b0, 1'b0, 1'b1, 5));
`ifdef ANIM_PAUSE_EN
    tbl.push_back(wt(1'b0, 1'b0, 1'b0, FT));
`else
    tbl.push_back(wt(1'b0, 1'b0, 1'b0, FT - 5));
`endif
    // reset asserted at ERASE pix 2
    tbl.push_back(erase(1'b1, 1'b0, 1'b0, 1'b0, 2, 0));
    tbl.push_back(erase(1'b0, 1'b0, 1'b0, 1'b0, 1, 2));
    tbl.push_back(draw(1'b1, 1'b0, 1'b0, 1'b0, 8, 0));
    tbl.push_back(check(1'b0, 1'b0));
    tbl.push_back(wt(1'b0, 1'b0, 1'b0, FT));
    tbl.push_back(erase(1'b1, 1'b0, 1'b0, 1'b0, 8, 0));
    tbl.push_back(load());
    // reset while in OVER
    tbl.push_back(draw(1'b1, 1'b0, 1'b0, 1'b0, 8, 0));
    tbl.push_back(check(1'b1, 1'b0));
    tbl.push_back(over(1'b1, 1'b0, 2, 0));
    tbl.push_back(over(1'b0, 1'b0, 1, 2));
    tbl.push_back(draw(1'b1, 1'b0, 1'b0, 1'b0, 3, 0));

    repeat (2) @(posedge clk);
    foreach (tbl[k]) begin
      for (int i = 0; i < tbl[k].len; i++) begin
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        reset_n    = tbl[k].rn;
        touch_edge = tbl[k].tch;
        restart    = tbl[k].rst;
        pause      = tbl[k].pse;
        n     = tbl[k].base + i;
        e.cyc = cyc;
        e.pl  = tbl[k].pl;
        e.o   = tbl[k].o;
        e.me  = tbl[k].me;
        e.ld  = tbl[k].ld;
        e.go  = tbl[k].go;
        e.pix = tbl[k].sw ? n % PC : 0;
        e.obj = tbl[k].sw ? (n / PC) % NO : 0;
        sb.push_back(e);
        cyc++;
      end
    end
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
